note_duration_player: RTL and testbench
=======================================

# note_duration_player

Playback stage between the score reader and the three-tone generator. It waits for the score-RAM data to settle, then latches a 4-bit key code and a 4-bit duration. It drives the matching one-hot note line for the duration minus a short articulation gap, holds silence for the gap, and pulses `Over` so the reader advances to the next address. The tone generator consumes `NoteArray` directly.

## Interface
- `BEAT_CYCLES`, default 12_500_000: clock cycles per duration unit (1/8 s at 100 MHz).
- `GAP_CYCLES`, default 1_000_000: silent cycles at the end of every note. Must satisfy 1 ≤ GAP_CYCLES < BEAT_CYCLES.
- `SETTLE_CYCLES`, default 2: wait between start or advance and latching the inputs. Covers the reader address register plus the RAM output register. Minimum 1.
- `KEY_BITS`, default 4: key code width.
- `TIME_BITS`, default 4: duration width.

Ports (one clock; reset is asynchronous and active-low):
- `CLK` input, 1 bit: single clock, rising edge.
- `RESET` input, 1 bit: asynchronous, active-low reset.
- `Start` input, 1 bit: level enable; high while the score is not finished.
- `Note` input, KEY_BITS: key code.
- `Duration` input, TIME_BITS: length in beats.
- `NoteArray` output, 3 bits: registered one-hot note drive; bit0 = C, bit1 = D, bit2 = E.
- `Over` output, 1 bit: registered one-cycle pulse at the end of each note.
- `Busy` output, 1 bit: high in every state except IDLE.

## Operation
- **States:** IDLE, SETTLE, PLAY, GAP, DONE.
- **IDLE:** if `Start`=1, go to SETTLE and clear the settle counter.
- **SETTLE:** count SETTLE_CYCLES cycles. On the last cycle, latch `Note` and `Duration`, load the counters, and transition:
  - `Duration`=0 → DONE; no sound, `Over` still pulses.
  - otherwise → PLAY.
- **Key decode at latch:**
  - 1 → 3'b001, 2 → 3'b010, 3 → 3'b100.
  - 0 and 4..15 → rest (3'b000). A rest is timed exactly like a note.
- **PLAY:** `NoteArray` holds the decoded value for exactly D×BEAT_CYCLES − GAP_CYCLES cycles, then → GAP.
- **GAP:** `NoteArray`=0 for exactly GAP_CYCLES cycles, then → DONE.
- **DONE:** `Over`=1 for one cycle. Next state is SETTLE if `Start`=1, else IDLE.
- **Abort:** `Start`=0 in SETTLE, PLAY or GAP → IDLE on the next edge. `NoteArray` clears with that edge, and `Over` does not pulse.
- **Counters:**
  - Cycle counter is $clog2(BEAT_CYCLES) bits and wraps at BEAT_CYCLES−1.
  - Beat counter is TIME_BITS bits and decrements on each wrap.
  - PLAY ends when the beat counter is 1 and the cycle counter is BEAT_CYCLES−GAP_CYCLES−1.
  - No multiplication in hardware.
- **Held inputs:** latched `Note`/`Duration` are held for the whole note; input changes after the latch are ignored.

## Timing
- **Reset values:** state = IDLE, `NoteArray`=0, `Over`=0, `Busy`=0, all counters 0.
- **Reset mid-note:** silences the outputs immediately (asynchronously), with no `Over` pulse.
- **Start latency:** `Start` sampled high at edge e0. Inputs are latched at edge e0+SETTLE_CYCLES, and `NoteArray` becomes valid after that same edge.
- **Note period:** from first `NoteArray` cycle to `Over` is D×BEAT_CYCLES cycles, then 1 cycle of `Over`.
- **Back-to-back notes:**
  - The reader advances its address on the `Over` edge.
  - The next latch occurs SETTLE_CYCLES edges after the DONE→SETTLE edge.
  - The inter-note gap beyond GAP_CYCLES is therefore 1 + SETTLE_CYCLES cycles, constant.
- **Start falling in DONE:** the `Over` pulse still completes, then the block goes to IDLE.
- **Maximum duration:** D=15 plays for 15×BEAT_CYCLES cycles; the beat counter never wraps.

## Structure
- **`note_player_pkg`:**
  - state enum `np_state_t` (IDLE, SETTLE, PLAY, GAP, DONE);
  - key constants KEY_REST=0, KEY_C=1, KEY_D=2, KEY_E=3;
  - decode function `key_to_onehot`.
- **Sub-module `beat_timer`:**
  - contains the cycle and beat counters;
  - inputs: load, duration;
  - outputs: `play_end` and `gap_end` strobes.
- The top level holds the FSM, the input latches and the output registers.

## Test plan
Bench parameters: BEAT_CYCLES=10, GAP_CYCLES=2, SETTLE_CYCLES=2.
1. `Note`=2, `Duration`=3, `Start` held high → `NoteArray`=3'b010 for 28 cycles, then 0 for 2 cycles, then `Over` for 1 cycle.
2. `Note`=0, `Duration`=1 → `NoteArray`=0 throughout and `Over` asserts 10 cycles after the latch; `Note`=9 gives the same result.
3. `Duration`=0 → `Over` asserts on the cycle after the latch, with no PLAY or GAP.
4. Sequence (1,1), (3,2) with `Start` held high → second note latched 3 cycles after the first `Over` (1-cycle DONE + 2 SETTLE edges), then `NoteArray`=3'b100 for 18 cycles, then 0 for 2 cycles, then `Over` for 1 cycle.
5. `Start` dropped 5 cycles into PLAY of (1,4) → `NoteArray`=0 on the next edge, block returns to IDLE, no `Over`.
6. `RESET` asserted in PLAY of (2,15) → `NoteArray`=0 and `Busy`=0 asynchronously; after release, `Start` high replays from SETTLE.

Source files
------------

// File: rtl/note_player_pkg.sv
// Shared types and key decoding for the note duration player.
// Key codes map onto the one-hot drive lines of the three-tone generator.
package note_player_pkg;

   typedef enum logic [2:0] {IDLE, SETTLE, PLAY, GAP, DONE} np_state_t;

   localparam int unsigned KEY_REST = 0;
   localparam int unsigned KEY_C    = 1;
   localparam int unsigned KEY_D    = 2;
   localparam int unsigned KEY_E    = 3;

   // Anything that is not C, D or E plays as a rest of the same length.
   function automatic logic [2:0] key_to_onehot(input int unsigned key);
      case (key)
         KEY_REST: key_to_onehot = 3'b000;
         KEY_C:    key_to_onehot = 3'b001;
         KEY_D:    key_to_onehot = 3'b010;
         KEY_E:    key_to_onehot = 3'b100;
         default:  key_to_onehot = 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/note_duration_player_beat_timer.sv
// Cycle and beat counters for one note; strobes the end of the sounding
// part (play_end) and the end of the articulation gap (gap_end).
module beat_timer #(
   parameter int BEAT_CYCLES = 12_500_000,
   parameter int GAP_CYCLES  = 1_000_000,
   parameter int TIME_BITS   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 run,
   input  logic [TIME_BITS-1:0] duration,
   output logic                 play_end,
   output logic                 gap_end
);

   localparam int CW = $clog2(BEAT_CYCLES);
   localparam logic [CW-1:0] CYC_LAST      = CW'(BEAT_CYCLES - 1);
   localparam logic [CW-1:0] CYC_PLAY_LAST = CW'(BEAT_CYCLES - GAP_CYCLES - 1);
   localparam logic [TIME_BITS-1:0] BEAT_ONE = TIME_BITS'(1);

   logic [CW-1:0]        cyc;
   logic [TIME_BITS-1:0] beat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc  <= '0;
         beat <= '0;
      end else if (load) begin
         cyc  <= '0;
         beat <= duration;
      end else if (run) begin
         if (cyc == CYC_LAST) begin
            cyc  <= '0;
            beat <= beat - 1'b1;
         end else begin
            cyc <= cyc + 1'b1;
         end
      end
   end

   // Both strobes fall inside the final beat, so no D*BEAT product is needed.
   assign play_end = (beat == BEAT_ONE) && (cyc == CYC_PLAY_LAST);
   assign gap_end  = (beat == BEAT_ONE) && (cyc == CYC_LAST);

endmodule

// File: rtl/note_duration_player.sv
// Score playback stage: settles, latches key/duration, drives the one-hot
// note line, inserts the articulation gap and pulses Over to advance the reader.
module note_duration_player
   import note_player_pkg::*;
#(
   parameter int BEAT_CYCLES   = 12_500_000,
   parameter int GAP_CYCLES    = 1_000_000,
   parameter int SETTLE_CYCLES = 2,
   parameter int KEY_BITS      = 4,
   parameter int TIME_BITS     = 4
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 Start,
   input  logic [KEY_BITS-1:0]  Note,
   input  logic [TIME_BITS-1:0] Duration,
   output logic [2:0]           NoteArray,
   output logic                 Over,
   output logic                 Busy
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

   np_state_t     state, state_nx;
   logic [SW-1:0] settle_cnt, settle_nx;
   logic          latch;
   logic          play_end, gap_end;

   beat_timer #(
      .BEAT_CYCLES (BEAT_CYCLES),
      .GAP_CYCLES  (GAP_CYCLES),
      .TIME_BITS   (TIME_BITS)
   ) u_timer (
      .clk      (CLK),
      .rst_n    (RESET),
      .load     (latch),
      .run      ((state == PLAY) || (state == GAP)),
      .duration (Duration),
      .play_end (play_end),
      .gap_end  (gap_end)
   );

   always_comb begin
      state_nx  = state;
      settle_nx = settle_cnt;
      latch     = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
               state_nx  = SETTLE;
               settle_nx = '0;
            end
         end
         SETTLE: begin
            if (!Start) begin
               state_nx = IDLE;
            end else if (settle_cnt == SETTLE_LAST) begin
               latch    = 1'b1;
               state_nx = (Duration == '0) ? DONE : PLAY;
            end else begin
               settle_nx = settle_cnt + 1'b1;
            end
         end
         PLAY: begin
            if (!Start)        state_nx = IDLE;
            else if (play_end) state_nx = GAP;
         end
         GAP: begin
            if (!Start)       state_nx = IDLE;
            else if (gap_end) state_nx = DONE;
         end
         DONE: begin
            // The Over pulse always completes; Start only picks the successor.
            state_nx  = Start ? SETTLE : IDLE;
            settle_nx = '0;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state      <= IDLE;
         settle_cnt <= '0;
         NoteArray  <= '0;
         Over       <= 1'b0;
      end else begin
         state      <= state_nx;
         settle_cnt <= settle_nx;
         Over       <= (state_nx == DONE);
         // NoteArray itself is the held copy of the latched key.
         if (latch)
            NoteArray <= (Duration == '0) ? 3'b000 : key_to_onehot(32'(Note));
         else if (state_nx != PLAY)
            NoteArray <= '0;
      end
   end

   assign Busy = (state != IDLE);

endmodule

// File: tb/tb_note_duration_player.sv
// Scoreboard bench for note_duration_player with short beats.
// A monitor turns each Busy segment into a record and compares it with the queue.
module tb_note_duration_player;

   localparam int BEAT   = 10;
   localparam int GAPC   = 2;
   localparam int SETTLE = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] note = '0;
   logic [3:0] dur = '0;
   logic [2:0] note_array;
   logic       over;
   logic       busy;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int kind;      // 0 = ended with Over, 1 = ended without Over
      int val;
      int first_on;
      int on;
      int total;
      int split;
   } rec_t;

   rec_t exp_q[$];

   always #5 clk = ~clk;

   note_duration_player #(
      .BEAT_CYCLES   (BEAT),
      .GAP_CYCLES    (GAPC),
      .SETTLE_CYCLES (SETTLE),
      .KEY_BITS      (4),
      .TIME_BITS     (4)
   ) dut (
      .CLK       (clk),
      .RESET     (rst_n),
      .Start     (start),
      .Note      (note),
      .Duration  (dur),
      .NoteArray (note_array),
      .Over      (over),
      .Busy      (busy)
   );

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic push_rec(input int kind, input int val, input int on, input int total);
      rec_t r;
      r.kind     = kind;
      r.val      = val;
      r.first_on = (on > 0) ? SETTLE : -1;
      r.on       = on;
      r.total    = total;
      r.split    = 0;
      exp_q.push_back(r);
   endtask

   // Monitor state for the current Busy segment.
   int m_total = 0, m_on = 0, m_first = -1, m_val = 0, m_split = 0;
   bit m_active = 1'b0, m_off_after_on = 1'b0;

   task automatic emit(input int kind);
      rec_t e;
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL unexpected_record: got kind %0d val %0d on %0d total %0d, expected none",
                  kind, m_val, m_on, m_total);
      end else begin
         e = exp_q.pop_front();
         check("rec_kind", kind, e.kind);
         check("rec_val", m_val, e.val);
         check("rec_first_on", m_first, e.first_on);
         check("rec_on_cycles", m_on, e.on);
         check("rec_total_cycles", m_total, e.total);
         check("rec_contiguous", m_split, e.split);
      end
      m_total = 0; m_on = 0; m_first = -1; m_val = 0; m_split = 0;
      m_active = 1'b0; m_off_after_on = 1'b0;
   endtask

   always @(negedge clk) begin
      if (over === 1'b1) begin
         if (note_array != 3'b000) m_split = 1;
         emit(0);
      end else if (busy === 1'b1) begin
         if (note_array != 3'b000) begin
            if (m_first < 0) begin
               m_first = m_total;
               m_val   = int'(note_array);
            end else if (m_off_after_on || int'(note_array) != m_val) begin
               m_split = 1;
            end
            m_on++;
         end else if (m_first >= 0) begin
            m_off_after_on = 1'b1;
         end
         m_total++;
         m_active = 1'b1;
      end else if (m_active) begin
         emit(1);
      end
   end

   task automatic wait_over();
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (over !== 1'b1 && n < 1000);
      if (over !== 1'b1) check("over_timeout", 0, 1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      idle(3);
      check("reset_note_array", int'(note_array), 0);
      check("reset_over", int'(over), 0);
      check("reset_busy", int'(busy), 0);
      rst_n = 1'b1;
      idle(2);

      // D note for 3 beats; inputs scrambled after the latch must be ignored.
      note = 4'd2; dur = 4'd3;
      push_rec(0, 2, 28, 32);
      start = 1'b1;
      idle(5);
      note = 4'd3; dur = 4'd7;
      wait_over();
      start = 1'b0;
      idle(3);

      // Rests: key 0 and key 9, one beat each.
      note = 4'd0; dur = 4'd1;
      push_rec(0, 0, 0, 12);
      start = 1'b1;
      wait_over();
      start = 1'b0;
      idle(3);
      note = 4'd9; dur = 4'd1;
      push_rec(0, 0, 0, 12);
      start = 1'b1;
      wait_over();
      start = 1'b0;
      idle(3);

      // Zero duration: Over right after the latch.
      note = 4'd1; dur = 4'd0;
      push_rec(0, 0, 0, 2);
      start = 1'b1;
      wait_over();
      start = 1'b0;
      idle(3);

      // Back-to-back (1,1) then (3,2); reader updates inputs on the Over edge.
      note = 4'd1; dur = 4'd1;
      push_rec(0, 1, 8, 12);
      push_rec(0, 4, 18, 22);
      start = 1'b1;
      wait_over();
      note = 4'd3; dur = 4'd2;
      wait_over();
      start = 1'b0;
      idle(3);

      // Start dropped after 5 PLAY cycles of (1,4).
      note = 4'd1; dur = 4'd4;
      push_rec(1, 1, 5, 7);
      start = 1'b1;
      idle(7);
      start = 1'b0;
      idle(1);
      check("abort_note_array", int'(note_array), 0);
      check("abort_busy", int'(busy), 0);
      idle(3);

      // Asynchronous reset in PLAY of (2,15), then replay with Start held.
      note = 4'd2; dur = 4'd15;
      push_rec(1, 2, 7, 9);
      start = 1'b1;
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_note_array", int'(note_array), 0);
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_over", int'(over), 0);
      note = 4'd2; dur = 4'd1;
      push_rec(0, 2, 8, 12);
      idle(2);
      rst_n = 1'b1;
      wait_over();
      start = 1'b0;
      idle(5);

      check("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
